ula_acc: RTL and testbench
==========================

ULA_ACC -- requirements
Module: ula_acc

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning operand/accumulator/result width in bits (two's complement signed).
REQ-002 The block SHALL have port clk  input  1  single system clock, all state updates on rising edge.
REQ-003 The block SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid  input  1  command present on op/operand.
REQ-005 The block SHALL have port in_ready  output  1  block can accept a command this cycle.
REQ-006 The block SHALL have port op  input  3  command code: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 LOAD, 101 CLRF, 110 READ, 111 NOP.
REQ-007 The block SHALL have port operand  input  N  signed second operand (first operand is the accumulator).
REQ-008 The block SHALL have port out_valid  output  1  response present on result/flag_o.
REQ-009 The block SHALL have port out_ready  input  1  downstream accepts the response.
REQ-010 The block SHALL have port result  output  N  accumulator value after the command.
REQ-011 The block SHALL have port flag_o  output  1  signed overflow/underflow of this command.
REQ-012 The block SHALL have port flag_sticky  output  1  OR of flag_o since last CLRF or reset.
REQ-013 The block SHALL have port ops_count  output  8  number of responses accepted downstream, wraps modulo 256.

Function
REQ-014 The FSM SHALL have states IDLE, EXEC, RESP; in_ready SHALL be 1 only in IDLE, out_valid SHALL be 1 only in RESP.
REQ-015 IDLE: in_valid=1 at a rising edge SHALL capture op and operand and go to EXEC; otherwise stay in IDLE.
REQ-016 EXEC: at the next edge the accumulator, flag_o and flag_sticky SHALL update and the FSM SHALL go to RESP (response visible two edges after acceptance edge... i.e. out_valid high in the cycle after the EXEC edge).
REQ-017 RESP: result and flag_o SHALL be held stable while out_ready=0; out_ready=1 at an edge SHALL return to IDLE and increment ops_count.
REQ-018 AND/OR SHALL be bitwise acc&operand / acc|operand, flag_o=0.
REQ-019 ADD SHALL be acc+operand truncated to N bits; flag_o=1 iff acc and operand have equal sign and the result sign differs.
REQ-020 SUB SHALL be acc-operand truncated to N bits; flag_o=1 iff acc and operand have different sign and the result sign differs from acc.
REQ-021 LOAD SHALL set acc=operand, flag_o=0.
REQ-022 CLRF SHALL leave acc unchanged, flag_o=0, and clear flag_sticky (clear wins over any set in the same command).
REQ-023 READ and NOP SHALL leave acc and flag_sticky unchanged, flag_o=0; both SHALL still produce a response.
REQ-024 flag_sticky SHALL be set in the EXEC edge where flag_o becomes 1 and stay set until CLRF or reset.
REQ-025 Commands presented while in_ready=0 SHALL be ignored (not captured); op/operand changes after capture SHALL not affect the result.
REQ-026 ops_count SHALL wrap from 255 to 0 without side effects.

Reset
REQ-027 reset_n=0 SHALL immediately, independent of clk, force state IDLE, acc=0, result=0, flag_o=0, flag_sticky=0, ops_count=0, out_valid=0; in_ready SHALL be 1 while reset_n=0 is deasserted-pending? No: in_ready SHALL be 0 while reset_n=0 and 1 from the first cycle after release.
REQ-028 Reset asserted in EXEC or RESP SHALL discard the in-flight command with no response and no ops_count increment.

Verification
REQ-029 LOAD 0x7F, ADD 0x01 -> result 0x80, flag_o=1, flag_sticky=1; then READ -> result 0x80, flag_o=0, flag_sticky=1.
REQ-030 LOAD 0x80, SUB 0x01 -> result 0x7F, flag_o=1; LOAD 0x05, SUB 0xFB (-5) -> 0x0A, flag_o=0.
REQ-031 LOAD 0xF0, AND 0x3C -> 0x30; OR 0x0F -> 0x3F, flag_o=0; after an overflow, CLRF -> flag_sticky=0, result unchanged.
REQ-032 Hold out_ready=0 for 5 cycles in RESP -> out_valid=1, result/flag_o constant, in_ready=0, toggling in_valid/op captures nothing; out_ready=1 -> IDLE, ops_count+1.
REQ-033 Assert reset_n=0 mid-RESP with out_ready=0 -> out_valid, result, flags, ops_count all 0 asynchronously; after release first command behaves from acc=0.
REQ-034 Issue 256 NOP commands with out_ready=1 -> ops_count returns to 0, acc unchanged.

Source files
------------

// File: rtl/ula_acc.sv
// Accumulator ALU with a valid/ready command port and a valid/ready response port.
// Each accepted command takes IDLE -> EXEC -> RESP and yields exactly one response.
module ula_acc #(
    parameter int N = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          op,
    input  logic signed [N-1:0] operand,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [N-1:0] result,
    output logic                flag_o,
    output logic                flag_sticky,
    output logic [7:0]          ops_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_LOAD = 3'b100;
    localparam logic [2:0] OP_CLRF = 3'b101;

    state_t              state_q, state_d;
    logic signed [N-1:0] acc_q, acc_d;
    logic                flag_q, flag_d;
    logic                sticky_q, sticky_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [2:0]          op_q;
    logic signed [N-1:0] opd_q;
    logic                capture;
    logic signed [N-1:0] sum;
    logic signed [N-1:0] diff;

    function automatic logic add_ovf(input logic signed [N-1:0] a, input logic signed [N-1:0] b,
                                     input logic signed [N-1:0] s);
        return (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);
    endfunction

    function automatic logic sub_ovf(input logic signed [N-1:0] a, input logic signed [N-1:0] b,
                                     input logic signed [N-1:0] d);
        return (a[N-1] != b[N-1]) && (d[N-1] != a[N-1]);
    endfunction

    assign sum  = acc_q + opd_q;
    assign diff = acc_q - opd_q;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        flag_d   = flag_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        capture  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    capture = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                flag_d = 1'b0;
                case (op_q)
                    OP_AND:  acc_d = acc_q & opd_q;
                    OP_OR:   acc_d = acc_q | opd_q;
                    OP_ADD: begin
                        acc_d  = sum;
                        flag_d = add_ovf(acc_q, opd_q, sum);
                    end
                    OP_SUB: begin
                        acc_d  = diff;
                        flag_d = sub_ovf(acc_q, opd_q, diff);
                    end
                    OP_LOAD: acc_d = opd_q;
                    default: ;
                endcase
                // CLRF clears the sticky flag; every other command can only set it
                sticky_d = (op_q == OP_CLRF) ? 1'b0 : (sticky_q | flag_d);
                state_d  = RESP;
            end
            RESP: begin
                if (out_ready) begin
                    state_d = IDLE;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            flag_q   <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            flag_q   <= flag_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    // Command holding registers are only read in EXEC, so they need no reset
    always_ff @(posedge clk) begin
        if (capture) begin
            op_q  <= op;
            opd_q <= operand;
        end
    end

    assign in_ready    = reset_n && (state_q == IDLE);
    assign out_valid   = (state_q == RESP);
    assign result      = acc_q;
    assign flag_o      = flag_q;
    assign flag_sticky = sticky_q;
    assign ops_count   = cnt_q;

endmodule

// File: tb/tb_ula_acc.sv
// Directed bench for ula_acc: a command table with hand-computed results, plus
// sequences for response back-pressure, reset during a response and count wrap.
module tb_ula_acc;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_LOAD = 3'b100;
    localparam logic [2:0] OP_CLRF = 3'b101;
    localparam logic [2:0] OP_READ = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] op = 3'b000;
    logic [7:0] operand = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] result;
    logic       flag_o;
    logic       flag_sticky;
    logic [7:0] ops_count;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_cnt = 8'd0;
    logic [7:0] r_s;
    logic       f_s, s_s;

    typedef struct {
        logic [2:0] op;
        logic [7:0] opd;
        logic [7:0] res;
        logic       flg;
        logic       stk;
    } vec_t;

    vec_t vecs[19];

    ula_acc #(.N(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .operand    (operand),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .flag_o     (flag_o),
        .flag_sticky(flag_sticky),
        .ops_count  (ops_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present a command, let it be captured and executed; returns in RESP at a negedge.
    task automatic start_cmd(input logic [2:0] c, input logic [7:0] d);
        bit got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                got = 1;
                break;
            end
        end
        if (!got) check("in_ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b1;
        op       = c;
        operand  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op       = ~c;
        operand  = ~d;
        @(posedge clk);
        @(negedge clk);
        check("out_valid_resp", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic finish_cmd();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        exp_cnt   = exp_cnt + 8'd1;
    endtask

    task automatic run_cmd(input logic [2:0] c, input logic [7:0] d,
                           output logic [7:0] r, output logic f, output logic s);
        start_cmd(c, d);
        r = result;
        f = flag_o;
        s = flag_sticky;
        finish_cmd();
    endtask

    initial begin
        vecs[0]  = '{OP_LOAD, 8'h7F, 8'h7F, 1'b0, 1'b0};
        vecs[1]  = '{OP_ADD,  8'h01, 8'h80, 1'b1, 1'b1};
        vecs[2]  = '{OP_READ, 8'h55, 8'h80, 1'b0, 1'b1};
        vecs[3]  = '{OP_CLRF, 8'h00, 8'h80, 1'b0, 1'b0};
        vecs[4]  = '{OP_LOAD, 8'h80, 8'h80, 1'b0, 1'b0};
        vecs[5]  = '{OP_SUB,  8'h01, 8'h7F, 1'b1, 1'b1};
        vecs[6]  = '{OP_LOAD, 8'h05, 8'h05, 1'b0, 1'b1};
        vecs[7]  = '{OP_SUB,  8'hFB, 8'h0A, 1'b0, 1'b1};
        vecs[8]  = '{OP_CLRF, 8'hFF, 8'h0A, 1'b0, 1'b0};
        vecs[9]  = '{OP_LOAD, 8'hF0, 8'hF0, 1'b0, 1'b0};
        vecs[10] = '{OP_AND,  8'h3C, 8'h30, 1'b0, 1'b0};
        vecs[11] = '{OP_OR,   8'h0F, 8'h3F, 1'b0, 1'b0};
        vecs[12] = '{OP_NOP,  8'hAA, 8'h3F, 1'b0, 1'b0};
        vecs[13] = '{OP_ADD,  8'h80, 8'hBF, 1'b0, 1'b0};
        vecs[14] = '{OP_ADD,  8'hC0, 8'h7F, 1'b1, 1'b1};
        vecs[15] = '{OP_SUB,  8'h7F, 8'h00, 1'b0, 1'b1};
        vecs[16] = '{OP_CLRF, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[17] = '{OP_SUB,  8'h81, 8'h7F, 1'b0, 1'b0};
        vecs[18] = '{OP_ADD,  8'h7F, 8'hFE, 1'b1, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", {24'd0, result}, 32'd0);
        check("rst_flag_o", {31'd0, flag_o}, 32'd0);
        check("rst_sticky", {31'd0, flag_sticky}, 32'd0);
        check("rst_ops_count", {24'd0, ops_count}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Command table
        for (int i = 0; i < 19; i++) begin
            run_cmd(vecs[i].op, vecs[i].opd, r_s, f_s, s_s);
            check($sformatf("vec%0d_result", i), {24'd0, r_s}, {24'd0, vecs[i].res});
            check($sformatf("vec%0d_flag_o", i), {31'd0, f_s}, {31'd0, vecs[i].flg});
            check($sformatf("vec%0d_sticky", i), {31'd0, s_s}, {31'd0, vecs[i].stk});
        end
        @(negedge clk);
        check("table_ops_count", {24'd0, ops_count}, {24'd0, exp_cnt});

        // Back-pressure: response held for 5 cycles, new commands ignored
        start_cmd(OP_LOAD, 8'h5A);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            op       = OP_LOAD;
            operand  = 8'hFF - 8'(i);
            @(negedge clk);
            check($sformatf("hold%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("hold%0d_in_ready", i), {31'd0, in_ready}, 32'd0);
            check($sformatf("hold%0d_result", i), {24'd0, result}, 32'h5A);
            check($sformatf("hold%0d_flag_o", i), {31'd0, flag_o}, 32'd0);
        end
        in_valid = 1'b0;
        finish_cmd();
        @(negedge clk);
        check("hold_ops_count", {24'd0, ops_count}, {24'd0, exp_cnt});
        check("hold_in_ready", {31'd0, in_ready}, 32'd1);
        run_cmd(OP_READ, 8'h00, r_s, f_s, s_s);
        check("hold_read_result", {24'd0, r_s}, 32'h5A);

        // Reset asserted while a response is pending
        run_cmd(OP_LOAD, 8'h7F, r_s, f_s, s_s);
        start_cmd(OP_ADD, 8'h01);
        check("pre_rst_flag_o", {31'd0, flag_o}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_result", {24'd0, result}, 32'd0);
        check("arst_flag_o", {31'd0, flag_o}, 32'd0);
        check("arst_sticky", {31'd0, flag_sticky}, 32'd0);
        check("arst_ops_count", {24'd0, ops_count}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd0);
        exp_cnt = 8'd0;
        @(negedge clk);
        reset_n = 1'b1;
        run_cmd(OP_ADD, 8'h05, r_s, f_s, s_s);
        check("after_rst_result", {24'd0, r_s}, 32'h05);
        check("after_rst_flag_o", {31'd0, f_s}, 32'd0);
        @(negedge clk);
        check("after_rst_ops_count", {24'd0, ops_count}, 32'd1);

        // ops_count wrap over 256 NOPs
        run_cmd(OP_LOAD, 8'h42, r_s, f_s, s_s);
        for (int i = 0; i < 256; i++) run_cmd(OP_NOP, 8'h00, r_s, f_s, s_s);
        @(negedge clk);
        check("wrap_ops_count", {24'd0, ops_count}, {24'd0, exp_cnt});
        check("wrap_ops_count_abs", {24'd0, ops_count}, 32'd2);
        check("wrap_result", {24'd0, result}, 32'h42);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
